// File: rtl/axis_pkg.sv
// Shared AXI-Stream helpers: lane-index and wide-word width calculations.
package axis_pkg;

  localparam int DEF_DATA_WIDTH = 2;
  localparam int DEF_RATIO      = 4;

  // $clog2 yields 0 for a single lane; a counter still needs one bit.
  function automatic int lane_idx_w(input int ratio);
    int w;
    w = $clog2(ratio);
    return (w < 1) ? 1 : w;
  endfunction

  function automatic int wide_w(input int data_width, input int ratio);
    return data_width * ratio;
  endfunction

endpackage

// File: rtl/axis_upsizer.sv
// AXI-Stream width upsizer: packs RATIO narrow beats into one wide beat, closing early on tlast.
// Optional lane mask output enabled with AXIS_UPSIZER_KEEP_EN.
module axis_upsizer
  import axis_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int RATIO      = DEF_RATIO
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [DATA_WIDTH-1:0]       up_axis_tdata,
  input  logic                        up_axis_tlast,
  input  logic                        up_axis_tvalid,
  output logic                        up_axis_tready,
  output logic [DATA_WIDTH*RATIO-1:0] dn_axis_tdata,
`ifdef AXIS_UPSIZER_KEEP_EN
  output logic [RATIO-1:0]            dn_axis_tkeep,
`endif
  output logic                        dn_axis_tlast,
  output logic                        dn_axis_tvalid,
  input  logic                        dn_axis_tready
);

  localparam int LANE_W = lane_idx_w(RATIO);
  localparam int WIDE_W = wide_w(DATA_WIDTH, RATIO);

  logic [WIDE_W-1:0] acc_p0;
  logic [WIDE_W-1:0] wide_nxt;
  logic [LANE_W-1:0] lane_idx;
  logic [WIDE_W-1:0] data_p1;
  logic              last_p1;
  logic              vld_p1;
  logic              accept;
  logic              complete;

`ifdef AXIS_UPSIZER_KEEP_EN
  logic [RATIO-1:0] mask_p0;
  logic [RATIO-1:0] mask_nxt;
  logic [RATIO-1:0] keep_p1;
`endif

  assign up_axis_tready = ~vld_p1 | dn_axis_tready;
  assign accept         = up_axis_tvalid & up_axis_tready;
  assign complete       = accept & ((lane_idx == LANE_W'(RATIO - 1)) | up_axis_tlast);

  // Stage p0: accumulator with the current beat merged into its lane
  always_comb begin
    wide_nxt = acc_p0;
    wide_nxt[int'(lane_idx)*DATA_WIDTH +: DATA_WIDTH] = up_axis_tdata;
  end

`ifdef AXIS_UPSIZER_KEEP_EN
  assign mask_nxt = mask_p0 | (RATIO'(1) << lane_idx);
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_p0   <= '0;
      lane_idx <= '0;
`ifdef AXIS_UPSIZER_KEEP_EN
      mask_p0  <= '0;
`endif
    end else if (accept) begin
      if (complete) begin
        acc_p0   <= '0;
        lane_idx <= '0;
`ifdef AXIS_UPSIZER_KEEP_EN
        mask_p0  <= '0;
`endif
      end else begin
        acc_p0   <= wide_nxt;
        lane_idx <= lane_idx + LANE_W'(1);
`ifdef AXIS_UPSIZER_KEEP_EN
        mask_p0  <= mask_nxt;
`endif
      end
    end
  end

  // Stage p1: output register; a completing beat can refill it in the cycle it drains
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_p1 <= '0;
      last_p1 <= 1'b0;
      vld_p1  <= 1'b0;
`ifdef AXIS_UPSIZER_KEEP_EN
      keep_p1 <= '0;
`endif
    end else if (complete) begin
      data_p1 <= wide_nxt;
      last_p1 <= up_axis_tlast;
      vld_p1  <= 1'b1;
`ifdef AXIS_UPSIZER_KEEP_EN
      keep_p1 <= mask_nxt;
`endif
    end else if (dn_axis_tready) begin
      vld_p1  <= 1'b0;
    end
  end

  assign dn_axis_tdata  = data_p1;
  assign dn_axis_tlast  = last_p1;
  assign dn_axis_tvalid = vld_p1;
`ifdef AXIS_UPSIZER_KEEP_EN
  assign dn_axis_tkeep  = keep_p1;
`endif

endmodule

// File: tb/tb_axis_upsizer.sv
// Self-checking bench for axis_upsizer: cycle vector table, reset sequence, randomized scoreboard.
module tb_axis_upsizer;

  localparam int DW = 2;
  localparam int R  = 4;
  localparam int WW = DW * R;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [DW-1:0] up_tdata = '0;
  logic          up_tlast = 1'b0;
  logic          up_tvalid = 1'b0;
  logic          up_tready;
  logic [WW-1:0] dn_tdata;
  logic          dn_tlast;
  logic          dn_tvalid;
  logic          dn_tready = 1'b1;
`ifdef AXIS_UPSIZER_KEEP_EN
  logic [R-1:0]  dn_tkeep;
`endif

  axis_upsizer #(.DATA_WIDTH(DW), .RATIO(R)) dut (
    .clk            (clk),
    .rst            (rst),
    .up_axis_tdata  (up_tdata),
    .up_axis_tlast  (up_tlast),
    .up_axis_tvalid (up_tvalid),
    .up_axis_tready (up_tready),
    .dn_axis_tdata  (dn_tdata),
`ifdef AXIS_UPSIZER_KEEP_EN
    .dn_axis_tkeep  (dn_tkeep),
`endif
    .dn_axis_tlast  (dn_tlast),
    .dn_axis_tvalid (dn_tvalid),
    .dn_axis_tready (dn_tready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] d, input logic l, input logic r);
    @(posedge clk);
    #1;
    up_tvalid = v;
    up_tdata  = d;
    up_tlast  = l;
    dn_tready = r;
  endtask

  typedef struct {
    logic          v;
    logic [DW-1:0] d;
    logic          l;
    logic          r;
    logic          e_rdy;
    logic          e_vld;
    logic [WW-1:0] e_data;
    logic          e_last;
    logic [R-1:0]  e_keep;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic v, input logic [DW-1:0] d, input logic l, input logic r,
                              input logic e_rdy, input logic e_vld, input logic [WW-1:0] e_data,
                              input logic e_last, input logic [R-1:0] e_keep);
    vec_t t;
    t.v = v; t.d = d; t.l = l; t.r = r;
    t.e_rdy = e_rdy; t.e_vld = e_vld; t.e_data = e_data; t.e_last = e_last; t.e_keep = e_keep;
    return t;
  endfunction

  // Reference model state for the randomized phase
  bit            mon_en = 1'b0;
  int            cur_beats[$];
  logic [WW-1:0] exp_data_q[$];
  logic          exp_last_q[$];
  logic [R-1:0]  exp_keep_q[$];

  initial begin : monitor
    bit            hold_prev = 1'b0;
    logic [WW-1:0] hd;
    logic          hl;
    logic [WW-1:0] w;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (hold_prev) begin
          chk("hold_valid", 32'(dn_tvalid), 32'd1);
          chk("hold_data", 32'(dn_tdata), 32'(hd));
          chk("hold_last", 32'(dn_tlast), 32'(hl));
        end
        chk("rnd_tready", 32'(up_tready), 32'(!dn_tvalid || dn_tready));
        hold_prev = dn_tvalid && !dn_tready;
        hd = dn_tdata;
        hl = dn_tlast;
        if (dn_tvalid && dn_tready) begin
          if (exp_data_q.size() == 0) begin
            chk("rnd_unexpected_word", 32'd1, 32'd0);
          end else begin
            chk("rnd_data", 32'(dn_tdata), 32'(exp_data_q.pop_front()));
            chk("rnd_last", 32'(dn_tlast), 32'(exp_last_q.pop_front()));
`ifdef AXIS_UPSIZER_KEEP_EN
            chk("rnd_keep", 32'(dn_tkeep), 32'(exp_keep_q.pop_front()));
`else
            void'(exp_keep_q.pop_front());
`endif
          end
        end
        if (up_tvalid && up_tready) begin
          cur_beats.push_back(int'(up_tdata));
          if (cur_beats.size() == R || up_tlast) begin
            w = '0;
            for (int i = 0; i < cur_beats.size(); i++) w = w + (WW'(cur_beats[i]) << (i * DW));
            exp_data_q.push_back(w);
            exp_last_q.push_back(up_tlast);
            exp_keep_q.push_back(R'((1 << cur_beats.size()) - 1));
            cur_beats.delete();
          end
        end
      end
    end
  end

  initial begin
    // Directed cycle table: inputs for the cycle and outputs observed before its edge
    vecs.push_back(mk(1, 1, 0, 1, 1, 0, 8'h00, 0, 4'h0));
    vecs.push_back(mk(1, 2, 0, 1, 1, 0, 8'h00, 0, 4'h0));
    vecs.push_back(mk(1, 3, 0, 1, 1, 0, 8'h00, 0, 4'h0));
    vecs.push_back(mk(1, 0, 1, 1, 1, 0, 8'h00, 0, 4'h0));
    vecs.push_back(mk(0, 0, 0, 1, 1, 1, 8'h39, 1, 4'hF));
    vecs.push_back(mk(1, 3, 0, 1, 1, 0, 8'h00, 0, 4'h0));
    vecs.push_back(mk(1, 1, 1, 1, 1, 0, 8'h00, 0, 4'h0));
    vecs.push_back(mk(0, 0, 0, 1, 1, 1, 8'h07, 1, 4'h3));
    vecs.push_back(mk(1, 1, 1, 1, 1, 0, 8'h00, 0, 4'h0));
    vecs.push_back(mk(1, 2, 1, 1, 1, 1, 8'h01, 1, 4'h1));
    vecs.push_back(mk(1, 3, 1, 1, 1, 1, 8'h02, 1, 4'h1));
    vecs.push_back(mk(0, 0, 0, 1, 1, 1, 8'h03, 1, 4'h1));
    vecs.push_back(mk(1, 0, 0, 1, 1, 0, 8'h00, 0, 4'h0));
    vecs.push_back(mk(1, 1, 0, 1, 1, 0, 8'h00, 0, 4'h0));
    vecs.push_back(mk(1, 2, 0, 1, 1, 0, 8'h00, 0, 4'h0));
    vecs.push_back(mk(1, 3, 0, 1, 1, 0, 8'h00, 0, 4'h0));
    vecs.push_back(mk(1, 0, 0, 1, 1, 1, 8'hE4, 0, 4'hF));
    vecs.push_back(mk(1, 1, 0, 1, 1, 0, 8'h00, 0, 4'h0));
    vecs.push_back(mk(1, 2, 0, 1, 1, 0, 8'h00, 0, 4'h0));
    vecs.push_back(mk(1, 3, 1, 1, 1, 0, 8'h00, 0, 4'h0));
    vecs.push_back(mk(0, 0, 0, 1, 1, 1, 8'hE4, 1, 4'hF));
    vecs.push_back(mk(1, 1, 1, 0, 1, 0, 8'h00, 0, 4'h0));
    for (int k = 0; k < 5; k++) vecs.push_back(mk(1, 2, 0, 0, 0, 1, 8'h01, 1, 4'h1));
    vecs.push_back(mk(1, 2, 1, 1, 1, 1, 8'h01, 1, 4'h1));
    vecs.push_back(mk(0, 0, 0, 1, 1, 1, 8'h02, 1, 4'h1));
    vecs.push_back(mk(0, 0, 0, 1, 1, 0, 8'h00, 0, 4'h0));

    // Reset state
    #12;
    chk("rst_valid", 32'(dn_tvalid), 32'd0);
    chk("rst_last", 32'(dn_tlast), 32'd0);
    chk("rst_data", 32'(dn_tdata), 32'd0);
    chk("rst_tready", 32'(up_tready), 32'd1);
`ifdef AXIS_UPSIZER_KEEP_EN
    chk("rst_keep", 32'(dn_tkeep), 32'd0);
`endif
    @(posedge clk);
    #1 rst = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].v, vecs[i].d, vecs[i].l, vecs[i].r);
      @(negedge clk);
      chk($sformatf("vec%0d_tready", i), 32'(up_tready), 32'(vecs[i].e_rdy));
      chk($sformatf("vec%0d_valid", i), 32'(dn_tvalid), 32'(vecs[i].e_vld));
      if (vecs[i].e_vld) begin
        chk($sformatf("vec%0d_data", i), 32'(dn_tdata), 32'(vecs[i].e_data));
        chk($sformatf("vec%0d_last", i), 32'(dn_tlast), 32'(vecs[i].e_last));
`ifdef AXIS_UPSIZER_KEEP_EN
        chk($sformatf("vec%0d_keep", i), 32'(dn_tkeep), 32'(vecs[i].e_keep));
`endif
      end
    end

    // Reset in the middle of a partial word, then a clean full word
    drive(1, 3, 0, 1);
    drive(1, 3, 0, 1);
    @(posedge clk);
    #1;
    up_tvalid = 1'b0;
    rst = 1'b0;
    #2;
    chk("midrst_valid", 32'(dn_tvalid), 32'd0);
    chk("midrst_data", 32'(dn_tdata), 32'd0);
    chk("midrst_last", 32'(dn_tlast), 32'd0);
    chk("midrst_tready", 32'(up_tready), 32'd1);
    @(posedge clk);
    #1 rst = 1'b1;
    up_tvalid = 1'b1; up_tdata = 2; up_tlast = 1'b0;
    drive(1, 2, 0, 1);
    drive(1, 2, 0, 1);
    drive(1, 2, 1, 1);
    drive(0, 0, 0, 1);
    @(negedge clk);
    chk("postrst_valid", 32'(dn_tvalid), 32'd1);
    chk("postrst_data", 32'(dn_tdata), 32'hAA);
    chk("postrst_last", 32'(dn_tlast), 32'd1);
`ifdef AXIS_UPSIZER_KEEP_EN
    chk("postrst_keep", 32'(dn_tkeep), 32'hF);
`endif
    drive(0, 0, 0, 1);
    @(negedge clk);
    chk("postrst_drain", 32'(dn_tvalid), 32'd0);

    // Randomized traffic against the packing model
    mon_en = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      drive($urandom_range(0, 3) != 0, DW'($urandom), $urandom_range(0, 4) == 0,
            $urandom_range(0, 2) != 0);
    end
    for (int c = 0; c < 10; c++) drive(0, 0, 0, 1);
    @(negedge clk);
    mon_en = 1'b0;
    chk("rnd_queue_empty", 32'(exp_data_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axis_upsizer.md
# axis_upsizer

AXI-Stream width upsizer that packs RATIO consecutive narrow beats into one wide beat of DATA_WIDTH*RATIO bits. It sits directly downstream of the skid/pipeline register stage and consumes its stream. It closes a word early on tlast so packet boundaries are preserved on the wide side. The wide output is registered and fully backpressure-aware.

## Interface
- DATA_WIDTH, 2: width of one narrow upstream beat.
- RATIO, 4: narrow beats per wide beat; RATIO >= 2.
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  asynchronous reset, active-low (asserted when 0). One clock; reset is asynchronous and active-low.
- up_axis_tdata  in  DATA_WIDTH  narrow beat data.
- up_axis_tlast  in  1  last beat of packet.
- up_axis_tvalid  in  1  upstream beat valid.
- up_axis_tready  out  1  block accepts beat.
- dn_axis_tdata  out  DATA_WIDTH*RATIO  packed wide word; lane 0 in LSBs.
- dn_axis_tkeep  out  RATIO  lane-valid mask; present only with AXIS_UPSIZER_KEEP_EN.
- dn_axis_tlast  out  1  wide word ends packet.
- dn_axis_tvalid  out  1  wide word valid.
- dn_axis_tready  in  1  downstream accepts word.

## Operation
- Internal state: accumulator (DATA_WIDTH*RATIO), lane index lane_idx ($clog2(RATIO) bits), optional lane mask, output register (data, last, valid, keep).
- Lane counter states: EMPTY (lane_idx==0, accumulator clear) and FILLING (lane_idx 1..RATIO-1).
- Accept = up_axis_tvalid & up_axis_tready. An accepted beat is written to lane lane_idx, bits [lane_idx*DATA_WIDTH +: DATA_WIDTH].
- Completing beat: accepted with lane_idx==RATIO-1 or up_axis_tlast==1. The assembled word, including the current beat, loads the output register. dn_axis_tlast takes the value of up_axis_tlast. The accumulator clears to zero, lane_idx returns to 0 and the mask clears.
- Non-completing beat: lane_idx increments by 1.
- Unfilled lanes of an early-closed word are 0.
- up_axis_tready = ~dn_axis_tvalid | dn_axis_tready. It is combinational, does not depend on up_axis_tvalid, and applies to every beat.
- The output register drops valid when dn_axis_tready=1 and no completing beat arrives in the same cycle.
- Handshake on the same cycle (dn word drained and a new completing beat): the new word replaces the old one and dn_axis_tvalid stays 1.
- While dn_axis_tvalid=1 & dn_axis_tready=0: dn_axis_tdata, dn_axis_tlast and dn_axis_tkeep stay stable, and up_axis_tready=0.
- Reset (async assert): dn_axis_tvalid=0, dn_axis_tlast=0, dn_axis_tdata=0, dn_axis_tkeep=0, lane_idx=0, accumulator=0. up_axis_tready therefore reads 1 during and after reset. Any partial word held at reset is discarded.

## Timing
- Latency: wide word valid 1 cycle after its completing beat is accepted.
- Throughput: 1 narrow beat/cycle when downstream is ready, giving one wide word every RATIO cycles for full words.
- Back-to-back single-beat tlast packets produce one wide word per cycle.
- Reset release is synchronous to clk. The first beat can be accepted on the first edge after deassertion.

## Configuration
- AXIS_UPSIZER_KEEP_EN defined: the dn_axis_tkeep port exists. It is a thermometer mask of filled lanes, e.g. 4'b0011 for a 2-beat closed word and all-ones for a full word.
- AXIS_UPSIZER_KEEP_EN undefined: no tkeep port and no mask register. Partial words are identifiable only by zero padding and tlast.

## Structure
- Shared package axis_pkg: function for lane index width ($clog2 with minimum 1), and the LANE_W / WIDE_W localparam helpers.
- No sub-module. The accumulator, lane counter and output register live in one module.

## Test plan
- DATA_WIDTH=2, RATIO=4, dn_ready=1. Beats 1,2,3,0 with tlast on the 4th -> one word, dn_tdata=0x39, tlast=1, tkeep=4'b1111, one cycle after the 4th accept.
- Beats 3,1 with tlast on the 2nd -> dn_tdata=0x07, tlast=1, tkeep=4'b0011. The next packet starts at lane 0.
- dn_ready=0 with a word held -> up_tready=0 and outputs stable for 5 cycles. Raise dn_ready -> word consumed, up_tready=1 in the same cycle.
- Two beats accepted, then assert rst mid-word, release, then send beats 2,2,2,2 with tlast -> single word 0xAA, no residue from the earlier beats.
- Continuous 8 beats 0..3,0..3 with tlast only on the 8th and dn_ready=1 -> words 0xE4 (tlast=0), then 0xE4 (tlast=1). up_tready is never low.
- Three consecutive single-beat tlast packets (values 1,2,3) -> three words 0x01, 0x02, 0x03 on consecutive cycles, each with tlast=1.
